top_level: RTL and testbench
============================

// Module: top_level
// PURPOSE
// - Hardwired LFSR-stream decryptor ("program 2"). Reads 64 encrypted bytes from DM.core[64..127] and
//   recovers the 7-bit LFSR tap pattern (one of 9) and seed from the known space-character preamble.
// - Writes the 64 decrypted bytes to DM.core[0..63] and raises ack. Top of the design; the bench
//   pre-loads and reads back the internal memory hierarchically, so the instance is DM and the array is core.
// PARAMETERS
// - MSG_LEN      64   bytes decrypted per run
// - CIPHER_BASE  64   DM address of first encrypted byte
// - PLAIN_BASE   0    DM address of first decrypted byte
// - PRE_CHECK    10   leading bytes that must decrypt to 0x20 for a pattern to match (min preamble)
// - DM_DEPTH     256  data-memory words; addresses 128..255 are spare
// PORTS
// - clk   in   1  single clock; all state on rising edge
// - init  in   1  reset; asynchronous, active-low
// - req   in   1  high = hold/idle; falling to low launches a run
// - ack   out  1  high = run complete, DM.core[0..63] valid
// BEHAVIOUR
// - Reset (init low): FSM to IDLE, ack=0, counters/LFSR/pattern index cleared. DM contents NOT cleared.
// - Encryption model: cipher[i][6:0] = plain[i][6:0] ^ s[i]; cipher[i][7] = ^cipher[i][6:0];
//   s[i+1] = {s[i][5:0], ^(s[i] & ptrn)}; s[0] nonzero.
// - Tap table ptrn[0..8] = 60,48,78,72,6A,69,5C,7E,7B (hex).
// - DM: combinational read, synchronous write, one access per cycle.
// - FSM states:
//   - IDLE: ack=0; leave only when req==0.
//   - SEED: seed = core[64][6:0] ^ 7'h20; p=0.
//   - SEARCH: i=1..PRE_CHECK-1, one read per cycle; step candidate LFSR with ptrn[p] each cycle.
//     - If core[64+i][6:0] ^ s[i] != 7'h20: p++, restart at i=1 from seed.
//     - All PRE_CHECK bytes match: lock p. First match in index order wins.
//     - p reaches 9 with no match: lock p=0 and continue (no hang).
//   - DECRYPT: i=0..63, LFSR restarted from seed with locked ptrn. Per byte: read cycle, then write
//     cycle to core[i] with {1'b0, c[6:0]^s[i]}; if c[7] != ^c[6:0], write 8'h80 (parity-error marker).
//   - DONE: ack=1, held until req returns high (go IDLE, ack=0) or reset.
// - req rising to 1 in any non-IDLE state: abort to IDLE; bytes already written stay in DM.
// - Latency: ack high no more than 250 cycles after req falls (search max 9*9, decrypt 128, overhead).
// - LFSR and arithmetic strictly 7-bit; bit 7 of every decrypted byte is 0 except the 0x80 marker.
// - Reads only 64..127, writes only 0..63; never touches 128..255.
// STRUCTURE
// - Package decrypt_pkg: tap table LFSR_PTRN[9], MSG_LEN, CIPHER_BASE, PLAIN_BASE, PRE_CHECK, SPACE=8'h20, FSM state enum.
// - Sub-module data_mem (instance name DM, array logic [7:0] core[DM_DEPTH]); remaining FSM/LFSR in top_level.
// TESTING
// - ptrn 0x60, seed 0x01, preamble 10, "Mr. Watson, come here. I want to see you." space-padded to 64,
//   encrypted into 64..127 -> core[0..63] equals padded plaintext; 64/64 bytes correct.
// - ptrn 0x7B (index 8), seed 0x55, preamble 15 -> search locks p=8; 64/64 correct; ack within 250 cycles.
// - Message of 35 '@' (0x40), ptrn 0x5C, seed 0x7F -> core[10..44]=0x40, others 0x20.
// - Flip bit 7 of cipher byte 30 -> core[30]=8'h80; all other 63 bytes correct.
// - Hold req=1 for 100 cycles -> ack=0 throughout, core[0..63] unchanged.
// - init low mid-DECRYPT -> ack=0 immediately; after init and req released, full run completes correctly.

Source files
------------

// File: rtl/decrypt_pkg.sv
// Shared constants, tap table, FSM state type and LFSR step for the
// hardwired LFSR-stream decryptor.
package decrypt_pkg;

    localparam int unsigned MSG_LEN     = 64;
    localparam int unsigned CIPHER_BASE = 64;
    localparam int unsigned PLAIN_BASE  = 0;
    localparam int unsigned PRE_CHECK   = 10;
    localparam int unsigned DM_DEPTH    = 256;
    localparam int unsigned NUM_PTRN    = 9;

    localparam logic [7:0] SPACE  = 8'h20;
    localparam logic [6:0] SPACE7 = SPACE[6:0];

    localparam logic [6:0] LFSR_PTRN [NUM_PTRN] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_SEARCH,
        S_DREAD,
        S_DWRITE,
        S_DONE
    } state_e;

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: combinational read, synchronous write, one shared
// address so only one access can happen per cycle. Contents are never reset.
module data_mem
    import decrypt_pkg::*;
#(
    parameter int unsigned DEPTH = DM_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o
);

    logic [7:0] core [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            core[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = core[addr_i];

endmodule

// File: rtl/top_level.sv
// LFSR-stream decryptor: recovers seed and tap pattern from the space preamble
// of DM[64..127], then writes the decrypted message into DM[0..63].
module top_level
    import decrypt_pkg::*;
(
    input  logic clk,
    input  logic init,
    input  logic req,
    output logic ack
);

    localparam int unsigned AW = $clog2(DM_DEPTH);

    state_e        state_q, state_d;
    logic [5:0]    idx_q,   idx_d;
    logic [3:0]    pidx_q,  pidx_d;
    logic [6:0]    seed_q,  seed_d;
    logic [6:0]    lfsr_q,  lfsr_d;
    logic [7:0]    cbyte_q, cbyte_d;

    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic [6:0]    ptrn;
    logic [6:0]    s_next;

    data_mem #(.DEPTH(DM_DEPTH)) DM (
        .clk_i   (clk),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    assign ptrn   = LFSR_PTRN[pidx_q];
    assign s_next = lfsr_step(lfsr_q, ptrn);

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pidx_q  <= '0;
            seed_q  <= '0;
            lfsr_q  <= '0;
            cbyte_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pidx_q  <= pidx_d;
            seed_q  <= seed_d;
            lfsr_q  <= lfsr_d;
            cbyte_q <= cbyte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pidx_d  = pidx_q;
        seed_d  = seed_q;
        lfsr_d  = lfsr_q;
        cbyte_d = cbyte_q;
        addr    = '0;
        we      = 1'b0;
        wdata   = '0;
        ack     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!req) begin
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                addr    = AW'(CIPHER_BASE);
                seed_d  = rdata[6:0] ^ SPACE7;
                lfsr_d  = rdata[6:0] ^ SPACE7;
                pidx_d  = '0;
                idx_d   = 6'd1;
                state_d = S_SEARCH;
            end
            S_SEARCH: begin
                addr = AW'(CIPHER_BASE) + AW'(idx_q);
                if ((rdata[6:0] ^ s_next) == SPACE7) begin
                    if (idx_q == 6'(PRE_CHECK - 1)) begin
                        idx_d   = '0;
                        lfsr_d  = seed_q;
                        state_d = S_DREAD;
                    end else begin
                        idx_d  = idx_q + 6'd1;
                        lfsr_d = s_next;
                    end
                end else begin
                    idx_d  = 6'd1;
                    lfsr_d = seed_q;
                    // Table exhausted: fall back to pattern 0 rather than stall.
                    if (pidx_q == 4'(NUM_PTRN - 1)) begin
                        pidx_d  = '0;
                        idx_d   = '0;
                        state_d = S_DREAD;
                    end else begin
                        pidx_d = pidx_q + 4'd1;
                    end
                end
            end
            S_DREAD: begin
                addr    = AW'(CIPHER_BASE) + AW'(idx_q);
                cbyte_d = rdata;
                state_d = S_DWRITE;
            end
            S_DWRITE: begin
                addr   = AW'(PLAIN_BASE) + AW'(idx_q);
                we     = 1'b1;
                wdata  = (cbyte_q[7] == ^cbyte_q[6:0]) ? {1'b0, cbyte_q[6:0] ^ lfsr_q} : 8'h80;
                lfsr_d = s_next;
                if (idx_q == 6'(MSG_LEN - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_DREAD;
                end
            end
            S_DONE: begin
                ack = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // req high outside IDLE abandons the run; suppress any pending write.
        if (state_q != S_IDLE && req) begin
            state_d = S_IDLE;
            we      = 1'b0;
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Directed bench for the LFSR-stream decryptor: loads encrypted messages into
// DM hierarchically and checks the decrypted result, latency and control.
module tb_top_level;

    logic clk;
    logic init;
    logic req;
    logic ack;

    int unsigned checks;
    int unsigned failures;

    logic [7:0] plain [64];
    logic [7:0] expv  [64];

    top_level dut (
        .clk  (clk),
        .init (init),
        .req  (req),
        .ack  (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic plain_msg(input int pre, input string msg);
        for (int i = 0; i < 64; i++) plain[i] = 8'h20;
        for (int k = 0; k < msg.len(); k++) plain[pre + k] = msg[k];
    endtask

    task automatic plain_fill(input int pre, input logic [7:0] ch, input int n);
        for (int i = 0; i < 64; i++) plain[i] = 8'h20;
        for (int k = 0; k < n; k++) plain[pre + k] = ch;
    endtask

    task automatic encrypt(input logic [6:0] p, input logic [6:0] seed);
        logic [6:0] s;
        logic [6:0] c7;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            c7 = plain[i][6:0] ^ s;
            dut.DM.core[64 + i] = {^c7, c7};
            s = {s[5:0], ^(s & p)};
        end
    endtask

    task automatic fill_out(input logic [7:0] v);
        for (int i = 0; i < 64; i++) dut.DM.core[i] = v;
    endtask

    task automatic expect_plain();
        for (int i = 0; i < 64; i++) expv[i] = plain[i];
    endtask

    task automatic run_wait(input string tag);
        int cyc;
        cyc = 0;
        req = 1'b0;
        while (ack !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " ack_within_250"}, 32'((ack === 1'b1) && (cyc <= 250)), 32'd1);
    endtask

    task automatic check_bytes(input string tag);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(dut.DM.core[i]), 32'(expv[i]));
    endtask

    task automatic release_req(input string tag);
        req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({tag, " ack_drop"}, 32'(ack), 32'd0);
    endtask

    initial begin
        string watson;
        int    seen;
        int    bad;

        checks   = 0;
        failures = 0;
        watson   = "Mr. Watson, come here. I want to see you.";
        init     = 1'b0;
        req      = 1'b1;
        for (int i = 128; i < 256; i++) dut.DM.core[i] = 8'(i) ^ 8'h5A;
        repeat (3) @(negedge clk);
        chk("reset ack", 32'(ack), 32'd0);

        // Idle hold: req high for 100 cycles must do nothing.
        plain_msg(10, watson);
        encrypt(7'h60, 7'h01);
        fill_out(8'hA5);
        init = 1'b1;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ack !== 1'b0) seen = 1;
        end
        chk("hold ack_never_high", 32'(seen), 32'd0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (dut.DM.core[i] !== 8'hA5) bad++;
        chk("hold out_unchanged", 32'(bad), 32'd0);

        // Test 1: ptrn 0x60, seed 0x01, preamble 10.
        expect_plain();
        run_wait("t1");
        check_bytes("t1");
        release_req("t1");

        // Test 2: ptrn 0x7B (last table entry), seed 0x55, preamble 15.
        plain_msg(15, watson);
        encrypt(7'h7B, 7'h55);
        fill_out(8'hA5);
        expect_plain();
        run_wait("t2");
        check_bytes("t2");
        release_req("t2");

        // Test 3: 35 '@' after a 10-space preamble, ptrn 0x5C, seed 0x7F.
        plain_fill(10, 8'h40, 35);
        encrypt(7'h5C, 7'h7F);
        fill_out(8'hA5);
        expect_plain();
        run_wait("t3");
        check_bytes("t3");
        // Asynchronous reset drops ack before any clock edge.
        @(negedge clk);
        #2 init = 1'b0;
        #1 chk("t3 async_reset_ack", 32'(ack), 32'd0);
        req = 1'b1;
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        chk("t3 post_reset_ack", 32'(ack), 32'd0);

        // Test 4: parity error on cipher byte 30.
        plain_msg(10, watson);
        encrypt(7'h60, 7'h01);
        dut.DM.core[94] = dut.DM.core[94] ^ 8'h80;
        fill_out(8'hA5);
        expect_plain();
        expv[30] = 8'h80;
        run_wait("t4");
        check_bytes("t4");
        release_req("t4");

        // Abort: req rises mid-decrypt; partial output stays, no ack.
        encrypt(7'h60, 7'h01);
        fill_out(8'hA5);
        req = 1'b0;
        repeat (40) @(negedge clk);
        req = 1'b1;
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ack !== 1'b0) seen = 1;
        end
        chk("abort ack_never_high", 32'(seen), 32'd0);
        chk("abort byte0_written", 32'(dut.DM.core[0]), 32'h20);
        chk("abort byte63_untouched", 32'(dut.DM.core[63]), 32'hA5);

        // Reset mid-decrypt, then a full clean run.
        fill_out(8'hA5);
        req = 1'b0;
        repeat (100) @(negedge clk);
        #2 init = 1'b0;
        #1 chk("midreset ack", 32'(ack), 32'd0);
        chk("midreset byte63_untouched", 32'(dut.DM.core[63]), 32'hA5);
        req = 1'b1;
        @(negedge clk);
        init = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset idle_ack", 32'(ack), 32'd0);
        fill_out(8'hA5);
        expect_plain();
        run_wait("t6");
        check_bytes("t6");
        release_req("t6");

        bad = 0;
        for (int i = 128; i < 256; i++) if (dut.DM.core[i] !== (8'(i) ^ 8'h5A)) bad++;
        chk("spare_region_untouched", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
